// File: rtl/scan_display_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a double-buffered glyph store.
// Latency: position/data registered 1 cycle after slot state; a commit lands at the next frame boundary.
// Backpressure: none; writes are always accepted, busy flags a commit waiting for the frame boundary.
module scan_display_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CODE_W       = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    localparam int AW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [CODE_W-1:0]     wr_code,
    input  logic                  wr_dp,
    input  logic                  commit,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic                  busy,
    output logic                  frame_done,
    output logic [NUM_DIGITS-1:0] position,
    output logic [7:0]            data
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]     PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [AW-1:0]     SLOT_LAST  = AW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [AW:0]       DIGITS     = (AW + 1)'(NUM_DIGITS);
    localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(63);

    localparam logic [0:0] CS_IDLE = 1'b0;
    localparam logic [0:0] CS_PEND = 1'b1;

    // Scan timing state
    logic [PW-1:0] pre_cnt;
    logic [AW-1:0] slot;
    logic          slot_tick;
    logic          frame_bnd;

    // Blink state
    logic [BW-1:0] blink_cnt;
    logic          blink_vis;

    // Commit handshake state
    logic [0:0]    commit_st;
    logic          xfer;

    // Double-buffered glyph store
    logic [CODE_W-1:0] sh_code [NUM_DIGITS];
    logic              sh_dp   [NUM_DIGITS];
    logic [CODE_W-1:0] ac_code [NUM_DIGITS];
    logic              ac_dp   [NUM_DIGITS];
    logic              wr_ok;

    // Output staging
    logic                  digit_lit;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [7:0]            seg_nxt;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g,dp}; dp is left off here.
    function automatic logic [7:0] glyph(input logic [CODE_W-1:0] code);
        logic [31:0] idx;
        logic [7:0]  seg;
        idx = 32'(code);
        case (idx)
            32'd0:   seg = 8'b0000_0011;
            32'd1:   seg = 8'b1001_1111;
            32'd2:   seg = 8'b0010_0101;
            32'd3:   seg = 8'b0000_1101;
            32'd4:   seg = 8'b1001_1001;
            32'd5:   seg = 8'b0100_1001;
            32'd6:   seg = 8'b0100_0001;
            32'd7:   seg = 8'b0001_1111;
            32'd8:   seg = 8'b0000_0001;
            32'd9:   seg = 8'b0000_1001;
            32'd10:  seg = 8'b0001_0001;
            32'd11:  seg = 8'b1100_0001;
            32'd12:  seg = 8'b0110_0011;
            32'd13:  seg = 8'b1000_0101;
            32'd14:  seg = 8'b0110_0001;
            32'd15:  seg = 8'b0111_0001;
            32'd18:  seg = 8'b1111_0111;
            32'd21:  seg = 8'b1110_0011;
            32'd22:  seg = 8'b0101_0101;
            32'd23:  seg = 8'b1101_0101;
            32'd24:  seg = 8'b1100_0101;
            32'd25:  seg = 8'b0011_0001;
            32'd28:  seg = 8'b0101_1001;
            32'd32:  seg = 8'b0100_0111;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    assign slot_tick  = (pre_cnt == PRE_LAST);
    assign frame_bnd  = slot_tick && (slot == SLOT_LAST);
    assign frame_done = frame_bnd;
    assign busy       = (commit_st == CS_PEND);
    assign xfer       = frame_bnd && busy;
    assign wr_ok      = wr_en && ({1'b0, wr_addr} < DIGITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (slot_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (slot_tick) begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (frame_bnd) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // A commit arriving while a transfer is pending is absorbed; the pending one clears at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_st <= CS_IDLE;
        end else begin
            case (commit_st)
                CS_IDLE: if (commit) commit_st <= CS_PEND;
                CS_PEND: if (frame_bnd) commit_st <= CS_IDLE;
                default: commit_st <= CS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sh_code[i] <= CODE_BLANK;
                sh_dp[i]   <= 1'b0;
            end
        end else if (wr_ok) begin
            sh_code[wr_addr] <= wr_code;
            sh_dp[wr_addr]   <= wr_dp;
        end
    end

    // Transfer samples the shadow before any same-cycle write lands, so that write waits for the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                ac_code[i] <= CODE_BLANK;
                ac_dp[i]   <= 1'b0;
            end
        end else if (xfer) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                ac_code[i] <= sh_code[i];
                ac_dp[i]   <= sh_dp[i];
            end
        end
    end

    always_comb begin
        digit_lit  = digit_en[slot] && (!blink_mask[slot] || blink_vis);
        sel_onehot = NUM_DIGITS'(1) << slot;
        seg_nxt    = glyph(ac_code[slot]) & ~{7'b0, ac_dp[slot]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position <= '1;
            data     <= 8'hFF;
        end else if (digit_lit) begin
            position <= ~sel_onehot;
            data     <= seg_nxt;
        end else begin
            position <= '1;
            data     <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Bench for scan_display_ctrl: stimulus queues per-frame expectations, a frame monitor captures and compares.
module tb_scan_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [5:0] wr_code = '0;
    logic       wr_dp = 1'b0;
    logic       commit = 1'b0;
    logic [3:0] digit_en = 4'hF;
    logic [3:0] blink_mask = 4'h0;
    logic       busy;
    logic       frame_done;
    logic [3:0] position;
    logic [7:0] data;

    always #5 clk = ~clk;

    scan_display_ctrl #(
        .NUM_DIGITS   (4),
        .CODE_W       (6),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_code    (wr_code),
        .wr_dp      (wr_dp),
        .commit     (commit),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .busy       (busy),
        .frame_done (frame_done),
        .position   (position),
        .data       (data)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    typedef struct {
        int              frame;
        logic [3:0][3:0] pos;
        logic [3:0][7:0] dat;
        logic            busy;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input int fr, input logic [3:0] lit,
                                input logic [3:0][7:0] d, input logic b);
        exp_t e;
        e.frame = fr;
        e.busy  = b;
        for (int s = 0; s < 4; s++) begin
            e.pos[s] = lit[s] ? ~(4'b0001 << s) : 4'hF;
            e.dat[s] = lit[s] ? d[s] : 8'hFF;
        end
        return e;
    endfunction

    // Monitor: frame index counts frame_done pulses; slot s is mid-way at 3+4s cycles after the pulse.
    int         fcount = 0;
    int         since = 0;
    bit         mon_on = 1'b1;
    logic [3:0] cap_pos [4];
    logic [7:0] cap_dat [4];
    logic       cap_busy;

    task automatic check_frame();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].frame < fcount) begin
            chk("frame_missed", exp_q[0].frame, fcount);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].frame == fcount) begin
            e = exp_q.pop_front();
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("f%0d_pos_slot%0d", fcount, s), cap_pos[s], e.pos[s]);
                chk($sformatf("f%0d_data_slot%0d", fcount, s), cap_dat[s], e.dat[s]);
            end
            chk($sformatf("f%0d_busy", fcount), cap_busy, e.busy);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (frame_done) begin
                if (fcount > 0) chk("frame_period", since + 1, 16);
                fcount++;
                since = 0;
            end else begin
                since++;
            end
            if (fcount > 0 && since < 16 && (since % 4) == 3) begin
                cap_pos[since / 4] = position;
                cap_dat[since / 4] = data;
            end
            if (since == 11) cap_busy = busy;
            if (fcount > 0 && since == 15) check_frame();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Returns inside the boundary cycle, so inputs driven now are sampled on the boundary edge.
    task automatic sync_frame(output int f);
        int t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!frame_done && t < 100);
        if (!frame_done) chk("frame_wait_timeout", frame_done, 1);
        f = fcount;
    endtask

    task automatic write(input logic [1:0] a, input logic [5:0] c, input logic dp);
        wr_en = 1'b1; wr_addr = a; wr_code = c; wr_dp = dp;
        cyc(1);
        wr_en = 1'b0; wr_dp = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cyc(1);
        commit = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int t;

        rst_n = 1'b0;
        cyc(3);
        chk("rst_position", position, 4'hF);
        chk("rst_data", data, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;

        // Blank scan, then commit of 0,1,A,F
        sync_frame(f);
        exp_q.push_back(mk(f,     4'hF, {4{8'hFF}}, 1'b1));
        exp_q.push_back(mk(f + 1, 4'hF, {8'h71, 8'h11, 8'h9F, 8'h03}, 1'b0));
        cyc(2);
        write(2'd0, 6'h00, 1'b0);
        write(2'd1, 6'h01, 1'b0);
        write(2'd2, 6'h0A, 1'b0);
        write(2'd3, 6'h0F, 1'b0);
        do_commit();
        sync_frame(f);

        // Decimal point on digit 2
        sync_frame(f);
        exp_q.push_back(mk(f,     4'hF, {8'h71, 8'h11, 8'h9F, 8'h03}, 1'b1));
        exp_q.push_back(mk(f + 1, 4'hF, {8'h71, 8'h00, 8'h9F, 8'h03}, 1'b0));
        cyc(2);
        write(2'd2, 6'h08, 1'b1);
        do_commit();
        sync_frame(f);

        // Digit 2 disabled for one frame
        sync_frame(f);
        digit_en = 4'b1011;
        exp_q.push_back(mk(f, 4'b1011, {8'h71, 8'h00, 8'h9F, 8'h03}, 1'b0));
        sync_frame(f);
        digit_en = 4'hF;

        // Blink on digit 0: frames 0,1 visible, 2,3 dark, repeating from reset
        sync_frame(f);
        blink_mask = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(f + i, (((f + i) / 2) % 2 == 0) ? 4'hF : 4'hE,
                               {8'h71, 8'h00, 8'h9F, 8'h03}, 1'b0));
        end
        repeat (4) sync_frame(f);
        blink_mask = 4'h0;

        // Unlisted code 19 is blank
        exp_q.push_back(mk(f,     4'hF, {8'h71, 8'h00, 8'h9F, 8'h03}, 1'b1));
        exp_q.push_back(mk(f + 1, 4'hF, {8'h71, 8'h00, 8'hFF, 8'h03}, 1'b0));
        cyc(2);
        write(2'd1, 6'd19, 1'b0);
        do_commit();
        sync_frame(f);

        // Write and commit in the boundary cycle: transfer one frame later, including the write
        sync_frame(f);
        wr_en = 1'b1; wr_addr = 2'd3; wr_code = 6'd24; wr_dp = 1'b0; commit = 1'b1;
        cyc(1);
        wr_en = 1'b0; commit = 1'b0;
        exp_q.push_back(mk(f,     4'hF, {8'h71, 8'h00, 8'hFF, 8'h03}, 1'b1));
        exp_q.push_back(mk(f + 1, 4'hF, {8'hC5, 8'h00, 8'hFF, 8'h03}, 1'b0));
        sync_frame(f);

        // Letters M P S W, clearing the dp on digit 2
        sync_frame(f);
        exp_q.push_back(mk(f,     4'hF, {8'hC5, 8'h00, 8'hFF, 8'h03}, 1'b1));
        exp_q.push_back(mk(f + 1, 4'hF, {8'h47, 8'h59, 8'h31, 8'h55}, 1'b0));
        cyc(2);
        write(2'd0, 6'd22, 1'b0);
        write(2'd1, 6'd25, 1'b0);
        write(2'd2, 6'd28, 1'b0);
        write(2'd3, 6'd32, 1'b0);
        do_commit();
        sync_frame(f);

        t = 0;
        while (exp_q.size() > 0 && t < 40) begin
            cyc(1);
            t++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        // Asynchronous reset mid-slot with a commit pending
        do_commit();
        chk("busy_before_reset", busy, 1'b1);
        cyc(1);
        mon_on = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_position", position, 4'hF);
        chk("async_rst_data", data, 8'hFF);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_frame_done", frame_done, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("restart_slot0_position", position, 4'hE);
        chk("restart_slot0_data", data, 8'hFF);
        cyc(4);
        chk("restart_slot1_position", position, 4'hD);
        chk("restart_slot1_data", data, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
